// File: rtl/button_led_if.sv
// Button/LED channel bundle: raw buttons and clear in, LED drive, debounced levels and press reporting out.
interface button_led_if #(
    parameter int N_BTN = 3,
    parameter int CNT_W = 8
) ();
    localparam int IDX_W = (N_BTN > 1) ? $clog2(N_BTN) : 1;

    logic [N_BTN-1:0] btn;
    logic             clear;
    logic [N_BTN-1:0] led;
    logic [N_BTN-1:0] btn_stable;
    logic             press_valid;
    logic [IDX_W-1:0] press_idx;
    logic [CNT_W-1:0] press_count;

    modport master (
        output btn, clear,
        input  led, btn_stable, press_valid, press_idx, press_count
    );

    modport slave (
        input  btn, clear,
        output led, btn_stable, press_valid, press_idx, press_count
    );
endinterface

// File: rtl/button_led_ctrl.sv
// Debounced button front end with press-event reporting, saturating press counter and LED drive
// in momentary, latch-last or toggle mode.
module button_led_ctrl #(
    parameter int N_BTN        = 3,
    parameter int DEBOUNCE_CYC = 4,
    parameter int MODE         = 0,
    parameter int CNT_W        = 8
) (
    input  logic      clk,
    input  logic      rst_n,
    button_led_if.slave bus
);
    localparam int IDX_W = (N_BTN > 1) ? $clog2(N_BTN) : 1;
    localparam int DCW   = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

    logic [N_BTN-1:0] sync_a;
    logic [N_BTN-1:0] sync_s;
    logic [N_BTN-1:0] stable;
    logic [N_BTN-1:0] stable_prev;
    logic [DCW-1:0]   dcnt [N_BTN];

    logic [N_BTN-1:0] led_q;
    logic             pv_q;
    logic [IDX_W-1:0] idx_q;
    logic [CNT_W-1:0] count_q;

    logic [N_BTN-1:0] ev;
    logic             any_ev;
    logic [IDX_W-1:0] ev_idx;
    logic [N_BTN-1:0] ev_oh;
    logic [N_BTN-1:0] stable_oh;
    logic [N_BTN-1:0] led_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_a      <= '0;
            sync_s      <= '0;
            stable      <= '0;
            stable_prev <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                dcnt[i] <= '0;
            end
        end else begin
            sync_a      <= bus.btn;
            sync_s      <= sync_a;
            stable_prev <= stable;
            for (int i = 0; i < N_BTN; i++) begin
                if (sync_s[i] == stable[i]) begin
                    dcnt[i] <= '0;
                end else if (dcnt[i] == DCW'(DEBOUNCE_CYC - 1)) begin
                    stable[i] <= sync_s[i];
                    dcnt[i]   <= '0;
                end else begin
                    dcnt[i] <= dcnt[i] + DCW'(1);
                end
            end
        end
    end

    assign ev        = stable & ~stable_prev;
    assign any_ev    = |ev;
    assign ev_oh     = ev & (~ev + N_BTN'(1));
    assign stable_oh = stable & (~stable + N_BTN'(1));

    always_comb begin
        ev_idx = '0;
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (ev[i]) begin
                ev_idx = IDX_W'(i);
            end
        end
    end

    // Unsupported MODE values fall into the momentary branch.
    always_comb begin
        led_next = stable_oh;
        case (MODE)
            1:       led_next = any_ev ? ev_oh : led_q;
            2:       led_next = led_q ^ ev;
            default: led_next = stable_oh;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            led_q   <= '0;
            pv_q    <= 1'b0;
            idx_q   <= '0;
            count_q <= '0;
        end else if (bus.clear) begin
            led_q   <= '0;
            pv_q    <= 1'b0;
            count_q <= '0;
        end else begin
            led_q <= led_next;
            pv_q  <= any_ev;
            if (any_ev) begin
                idx_q <= ev_idx;
                if (count_q != '1) begin
                    count_q <= count_q + CNT_W'(1);
                end
            end
        end
    end

    assign bus.led         = led_q;
    assign bus.btn_stable  = stable;
    assign bus.press_valid = pv_q;
    assign bus.press_idx   = idx_q;
    assign bus.press_count = count_q;
endmodule

// File: tb/tb_button_led_ctrl.sv
// Directed bench for button_led_ctrl: momentary, latch, toggle and invalid-mode instances driven
// from a shared vector table plus hand sequences for clear and reset corner cases.
module tb_button_led_ctrl;
    logic clk;
    logic rst_n;

    int total = 0;
    int bad   = 0;

    button_led_if #(.N_BTN(3), .CNT_W(8)) b0 ();
    button_led_if #(.N_BTN(3), .CNT_W(8)) b1 ();
    button_led_if #(.N_BTN(3), .CNT_W(2)) b2 ();
    button_led_if #(.N_BTN(3), .CNT_W(8)) b3 ();

    button_led_ctrl #(.N_BTN(3), .DEBOUNCE_CYC(4), .MODE(0), .CNT_W(8))
        u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    button_led_ctrl #(.N_BTN(3), .DEBOUNCE_CYC(4), .MODE(1), .CNT_W(8))
        u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    button_led_ctrl #(.N_BTN(3), .DEBOUNCE_CYC(4), .MODE(2), .CNT_W(2))
        u2 (.clk(clk), .rst_n(rst_n), .bus(b2));
    button_led_ctrl #(.N_BTN(3), .DEBOUNCE_CYC(4), .MODE(3), .CNT_W(8))
        u3 (.clk(clk), .rst_n(rst_n), .bus(b3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         sel;
        logic [2:0] btn;
        int         cyc;
        logic [2:0] led;
        logic [2:0] stb;
        logic       pv;
        logic [1:0] idx;
        logic [7:0] cnt;
    } vec_t;

    vec_t vecs [25];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_btn(input int sel, input logic [2:0] v);
        case (sel)
            0: begin b0.btn = v; b3.btn = v; end
            1: b1.btn = v;
            default: b2.btn = v;
        endcase
    endtask

    task automatic read_out(input int sel, output logic [2:0] led, output logic [2:0] stb,
                            output logic pv, output logic [1:0] idx, output logic [7:0] cnt);
        case (sel)
            0: begin led = b0.led; stb = b0.btn_stable; pv = b0.press_valid;
                     idx = b0.press_idx; cnt = b0.press_count; end
            1: begin led = b1.led; stb = b1.btn_stable; pv = b1.press_valid;
                     idx = b1.press_idx; cnt = b1.press_count; end
            2: begin led = b2.led; stb = b2.btn_stable; pv = b2.press_valid;
                     idx = b2.press_idx; cnt = {6'd0, b2.press_count}; end
            default: begin led = b3.led; stb = b3.btn_stable; pv = b3.press_valid;
                     idx = b3.press_idx; cnt = b3.press_count; end
        endcase
    endtask

    task automatic check_one(input string tag, input int sel, input logic [2:0] e_led,
                             input logic [2:0] e_stb, input logic e_pv, input logic [1:0] e_idx,
                             input logic [7:0] e_cnt);
        logic [2:0] led, stb;
        logic       pv;
        logic [1:0] idx;
        logic [7:0] cnt;
        read_out(sel, led, stb, pv, idx, cnt);
        chk($sformatf("%s u%0d led", tag, sel), {5'd0, led}, {5'd0, e_led});
        chk($sformatf("%s u%0d btn_stable", tag, sel), {5'd0, stb}, {5'd0, e_stb});
        chk($sformatf("%s u%0d press_valid", tag, sel), {7'd0, pv}, {7'd0, e_pv});
        chk($sformatf("%s u%0d press_count", tag, sel), cnt, e_cnt);
        if (e_pv) chk($sformatf("%s u%0d press_idx", tag, sel), {6'd0, idx}, {6'd0, e_idx});
    endtask

    task automatic check_sel(input string tag, input int sel, input logic [2:0] e_led,
                             input logic [2:0] e_stb, input logic e_pv, input logic [1:0] e_idx,
                             input logic [7:0] e_cnt);
        check_one(tag, sel, e_led, e_stb, e_pv, e_idx, e_cnt);
        if (sel == 0) check_one(tag, 3, e_led, e_stb, e_pv, e_idx, e_cnt);
    endtask

    initial begin
        //          sel  btn    cyc led     stb     pv    idx  cnt
        vecs[0]  = '{0, 3'b010, 6, 3'b000, 3'b010, 1'b0, 2'd0, 8'd0};
        vecs[1]  = '{0, 3'b010, 1, 3'b010, 3'b010, 1'b1, 2'd1, 8'd1};
        vecs[2]  = '{0, 3'b010, 1, 3'b010, 3'b010, 1'b0, 2'd0, 8'd1};
        vecs[3]  = '{0, 3'b000, 6, 3'b010, 3'b000, 1'b0, 2'd0, 8'd1};
        vecs[4]  = '{0, 3'b000, 1, 3'b000, 3'b000, 1'b0, 2'd0, 8'd1};
        vecs[5]  = '{0, 3'b001, 3, 3'b000, 3'b000, 1'b0, 2'd0, 8'd1};
        vecs[6]  = '{0, 3'b000, 6, 3'b000, 3'b000, 1'b0, 2'd0, 8'd1};
        vecs[7]  = '{0, 3'b110, 7, 3'b010, 3'b110, 1'b1, 2'd1, 8'd2};
        vecs[8]  = '{0, 3'b100, 6, 3'b010, 3'b100, 1'b0, 2'd0, 8'd2};
        vecs[9]  = '{0, 3'b100, 1, 3'b100, 3'b100, 1'b0, 2'd0, 8'd2};
        vecs[10] = '{0, 3'b000, 7, 3'b000, 3'b000, 1'b0, 2'd0, 8'd2};
        vecs[11] = '{1, 3'b100, 7, 3'b100, 3'b100, 1'b1, 2'd2, 8'd1};
        vecs[12] = '{1, 3'b000, 7, 3'b100, 3'b000, 1'b0, 2'd0, 8'd1};
        vecs[13] = '{1, 3'b001, 7, 3'b001, 3'b001, 1'b1, 2'd0, 8'd2};
        vecs[14] = '{1, 3'b000, 7, 3'b001, 3'b000, 1'b0, 2'd0, 8'd2};
        vecs[15] = '{2, 3'b101, 7, 3'b101, 3'b101, 1'b1, 2'd0, 8'd1};
        vecs[16] = '{2, 3'b000, 7, 3'b101, 3'b000, 1'b0, 2'd0, 8'd1};
        vecs[17] = '{2, 3'b101, 7, 3'b000, 3'b101, 1'b1, 2'd0, 8'd2};
        vecs[18] = '{2, 3'b000, 7, 3'b000, 3'b000, 1'b0, 2'd0, 8'd2};
        vecs[19] = '{2, 3'b010, 7, 3'b010, 3'b010, 1'b1, 2'd1, 8'd3};
        vecs[20] = '{2, 3'b000, 7, 3'b010, 3'b000, 1'b0, 2'd0, 8'd3};
        vecs[21] = '{2, 3'b010, 7, 3'b000, 3'b010, 1'b1, 2'd1, 8'd3};
        vecs[22] = '{2, 3'b000, 7, 3'b000, 3'b000, 1'b0, 2'd0, 8'd3};
        vecs[23] = '{2, 3'b100, 7, 3'b100, 3'b100, 1'b1, 2'd2, 8'd3};
        vecs[24] = '{2, 3'b000, 7, 3'b100, 3'b000, 1'b0, 2'd0, 8'd3};

        rst_n = 1'b0;
        b0.btn = '0; b1.btn = '0; b2.btn = '0; b3.btn = '0;
        b0.clear = 1'b0; b1.clear = 1'b0; b2.clear = 1'b0; b3.clear = 1'b0;
        repeat (3) tick();
        for (int s = 0; s < 3; s++) check_sel("reset", s, 3'b000, 3'b000, 1'b0, 2'd0, 8'd0);
        rst_n = 1'b1;

        for (int k = 0; k < 25; k++) begin
            set_btn(vecs[k].sel, vecs[k].btn);
            repeat (vecs[k].cyc) tick();
            check_sel($sformatf("vec%0d", k), vecs[k].sel, vecs[k].led, vecs[k].stb,
                      vecs[k].pv, vecs[k].idx, vecs[k].cnt);
        end

        // Clear coinciding with a press event: event dropped, counter and LEDs zeroed.
        set_btn(0, 3'b001);
        repeat (6) tick();
        check_sel("clr_pre", 0, 3'b000, 3'b001, 1'b0, 2'd0, 8'd2);
        b0.clear = 1'b1; b3.clear = 1'b1;
        tick();
        check_sel("clr_edge", 0, 3'b000, 3'b001, 1'b0, 2'd0, 8'd0);
        b0.clear = 1'b0; b3.clear = 1'b0;
        tick();
        check_sel("clr_after", 0, 3'b001, 3'b001, 1'b0, 2'd0, 8'd0);
        set_btn(0, 3'b000);
        repeat (7) tick();
        check_sel("clr_rel", 0, 3'b000, 3'b000, 1'b0, 2'd0, 8'd0);

        // Clear on the saturated narrow counter in toggle mode.
        b2.clear = 1'b1;
        tick();
        check_sel("clr_sat", 2, 3'b000, 3'b000, 1'b0, 2'd0, 8'd0);
        b2.clear = 1'b0;
        tick();
        check_sel("clr_sat_hold", 2, 3'b000, 3'b000, 1'b0, 2'd0, 8'd0);

        // Reset in the middle of a debounce, button kept held through it.
        set_btn(0, 3'b010);
        repeat (4) tick();
        check_sel("mid_deb", 0, 3'b000, 3'b000, 1'b0, 2'd0, 8'd0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_sel("rst_mid", 0, 3'b000, 3'b000, 1'b0, 2'd0, 8'd0);
        check_sel("rst_mid", 1, 3'b000, 3'b000, 1'b0, 2'd0, 8'd0);
        repeat (6) tick();
        check_sel("rst_held6", 0, 3'b000, 3'b010, 1'b0, 2'd0, 8'd0);
        tick();
        check_sel("rst_held7", 0, 3'b010, 3'b010, 1'b1, 2'd1, 8'd1);
        tick();
        check_sel("rst_held8", 0, 3'b010, 3'b010, 1'b0, 2'd0, 8'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
